mip_dispatch_reader: RTL

Drain side of the MIP dispatch FIFO: pops a commanded number of 128-bit entries from the synchronous dispatch FIFO, compensating for its one-cycle registered read latency, and presents them downstream as a valid/ready stream with a last marker. Sits between the dispatch FIFO and the MIP compute pipeline; sustains one beat per cycle while the FIFO is non-empty and the consumer is ready.

---
 rtl/mip_dispatch_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mip_dispatch_reader.sv
// mip_dispatch_reader: drains the dispatch FIFO into a valid/ready
// stream, hiding the FIFO's one-cycle registered read latency.
module mip_dispatch_reader #(
  parameter int DATA_WIDTH  = 128,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_beats,
  output logic                   busy,
  output logic                   done,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_issue_left;
  logic [COUNT_WIDTH-1:0] r_send_left;
  logic [1:0]             r_occ;
  logic                   r_inflight;
  logic [DATA_WIDTH-1:0]  r_buf0;
  logic [DATA_WIDTH-1:0]  r_buf1;
  logic                   w_pop;
  logic                   w_rd_en;
  logic                   w_accept;
  logic [2:0]             w_level;

  assign m_valid  = (r_occ != 2'd0);
  assign w_pop    = m_valid & m_ready;
  assign w_accept = (r_state == S_IDLE) & start;

  // Entries owned after this cycle: buffered plus in flight, minus the
  // one leaving now. A pop only happens with occ>=1, so no underflow.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight}
                 - {2'b00, w_pop};

  assign w_rd_en = (r_state == S_RUN)
                 & ~fifo_empty
                 & (r_issue_left != '0)
                 & (w_level < 3'd2);

  assign fifo_rd_en = w_rd_en;
  assign m_data     = r_buf0;
  assign m_last     = m_valid & (r_send_left == C_ONE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FINISH);

  // Next-state selection for the command FSM.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_beats != '0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_FINISH;
          end
        end
      end
      S_RUN: begin
        if (w_pop && (r_send_left == C_ONE)) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue and send counters; both saturate at zero.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_issue_left <= '0;
      r_send_left  <= '0;
    end else if (w_accept) begin
      r_issue_left <= num_beats;
      r_send_left  <= num_beats;
    end else begin
      if (w_rd_en) begin
        r_issue_left <= r_issue_left - C_ONE;
      end
      if (w_pop && (r_send_left != '0)) begin
        r_send_left <= r_send_left - C_ONE;
      end
    end
  end

  // Two-entry output buffer fed by the delayed FIFO read data.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= w_rd_en;
      unique case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= fifo_rd_data;
          end else begin
            r_buf1 <= fifo_rd_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= fifo_rd_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
